output_layer_seq: RTL

//  Output layer of the 4-4-2 DNN; sits directly downstream of the 4-neuron hidden layer.

---
 rtl/dnn_pkg.sv | 20 ++
 rtl/output_layer_seq_relu_quant.sv | 32 +++
 rtl/output_layer_seq.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/dnn_pkg.sv
// Shared constants and types for the 4-4-2 DNN output layer.
// Holds the default widths, the activation ceiling and the output-layer FSM encoding.
package dnn_pkg;

    localparam int IN_W_DEF  = 12;
    localparam int Q_W_DEF   = 5;
    localparam int W_W_DEF   = 5;
    localparam int SHIFT_DEF = 3;
    localparam int ACC_W_DEF = 12;

    localparam int ACT_MAX = 2**(Q_W_DEF-1) - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACT  = 2'd1,
        MAC  = 2'd2,
        DONE = 2'd3
    } ol_state_t;

endpackage

// File: rtl/output_layer_seq_relu_quant.sv
// ReLU followed by a right shift and a clamp to the largest positive activation.
// Purely combinational; the result is always in the range 0..2^(Q_W-1)-1.
module relu_quant #(
    parameter int IN_W  = 12,
    parameter int Q_W   = 5,
    parameter int SHIFT = 3
) (
    input  logic signed [IN_W-1:0] raw_i,
    output logic signed [Q_W-1:0]  act_o
);

    localparam logic [IN_W-1:0] SAT = IN_W'(2**(Q_W-1) - 1);

    logic [IN_W-1:0] pos_s;
    logic [IN_W-1:0] shr_s;

    // Negative inputs clamp to zero, so the shift is on a non-negative value.
    always_comb begin
        if (raw_i[IN_W-1]) begin
            pos_s = '0;
        end else begin
            pos_s = raw_i;
        end
        shr_s = pos_s >> SHIFT;
        if (shr_s > SAT) begin
            act_o = SAT[Q_W-1:0];
        end else begin
            act_o = shr_s[Q_W-1:0];
        end
    end

endmodule

// File: rtl/output_layer_seq.sv
// Output layer of the 4-4-2 DNN: captures four hidden results, requantizes them and
// evaluates two output neurons with one shared multiply-accumulate over eight cycles.
module output_layer_seq
    import dnn_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int Q_W   = Q_W_DEF,
    parameter int W_W   = W_W_DEF,
    parameter int SHIFT = SHIFT_DEF,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic signed [IN_W-1:0]  in0,
    input  logic signed [IN_W-1:0]  in1,
    input  logic signed [IN_W-1:0]  in2,
    input  logic signed [IN_W-1:0]  in3,
    input  logic signed [W_W-1:0]   w48,
    input  logic signed [W_W-1:0]   w58,
    input  logic signed [W_W-1:0]   w68,
    input  logic signed [W_W-1:0]   w78,
    input  logic signed [W_W-1:0]   w49,
    input  logic signed [W_W-1:0]   w59,
    input  logic signed [W_W-1:0]   w69,
    input  logic signed [W_W-1:0]   w79,
    output logic                    in_ready,
    output logic signed [ACC_W-1:0] out0,
    output logic signed [ACC_W-1:0] out1,
    output logic                    out_valid,
    output logic                    overrun
);

    localparam int PROD_W = Q_W + W_W;

    ol_state_t state_q, state_d;

    logic signed [IN_W-1:0]  in_s      [4];
    logic signed [W_W-1:0]   w8_s      [4];
    logic signed [W_W-1:0]   w9_s      [4];
    logic signed [IN_W-1:0]  raw_q     [4];
    logic signed [IN_W-1:0]  raw_d     [4];
    logic signed [Q_W-1:0]   act_new_s [4];
    logic signed [Q_W-1:0]   act_q     [4];
    logic signed [Q_W-1:0]   act_d     [4];
    logic signed [ACC_W-1:0] res_q     [2];
    logic signed [ACC_W-1:0] res_d     [2];

    logic [2:0]              cnt_q, cnt_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W-1:0] out0_q, out0_d, out1_q, out1_d;
    logic                    out_valid_q, out_valid_d;
    logic                    overrun_q, overrun_d;

    logic signed [Q_W-1:0]    act_sel_s;
    logic signed [W_W-1:0]    w_sel_s;
    logic signed [PROD_W-1:0] prod_s;
    logic signed [ACC_W-1:0]  prod_ext_s;
    logic signed [ACC_W-1:0]  sum_s;

    assign in_s[0] = in0;
    assign in_s[1] = in1;
    assign in_s[2] = in2;
    assign in_s[3] = in3;
    assign w8_s[0] = w48;
    assign w8_s[1] = w58;
    assign w8_s[2] = w68;
    assign w8_s[3] = w78;
    assign w9_s[0] = w49;
    assign w9_s[1] = w59;
    assign w9_s[2] = w69;
    assign w9_s[3] = w79;

    for (genvar g = 0; g < 4; g++) begin : g_rq
        relu_quant #(
            .IN_W  (IN_W),
            .Q_W   (Q_W),
            .SHIFT (SHIFT)
        ) u_rq (
            .raw_i (raw_q[g]),
            .act_o (act_new_s[g])
        );
    end

    assign in_ready  = (state_q == IDLE) || (state_q == DONE);
    assign out0      = out0_q;
    assign out1      = out1_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;

    // cnt[2] picks the neuron, cnt[1:0] the hidden input; the width rule keeps the sum from wrapping.
    always_comb begin
        act_sel_s = act_q[cnt_q[1:0]];
        if (cnt_q[2]) begin
            w_sel_s = w9_s[cnt_q[1:0]];
        end else begin
            w_sel_s = w8_s[cnt_q[1:0]];
        end
        prod_s     = PROD_W'(act_sel_s) * PROD_W'(w_sel_s);
        prod_ext_s = {{(ACC_W-PROD_W){prod_s[PROD_W-1]}}, prod_s};
        sum_s      = acc_q + prod_ext_s;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = in_valid ? ACT : IDLE;
            ACT:     state_d = MAC;
            MAC:     state_d = (cnt_q == 3'd7) ? DONE : MAC;
            DONE:    state_d = in_valid ? ACT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output next values.
    always_comb begin
        raw_d       = raw_q;
        act_d       = act_q;
        res_d       = res_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        out0_d      = out0_q;
        out1_d      = out1_q;
        out_valid_d = 1'b0;
        overrun_d   = overrun_q | (in_valid & ~in_ready);
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    raw_d = in_s;
                end else begin
                    raw_d = raw_q;
                end
            end
            ACT: begin
                act_d = act_new_s;
                cnt_d = 3'd0;
                acc_d = '0;
            end
            MAC: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q[1:0] == 2'd3) begin
                    res_d[cnt_q[2]] = sum_s;
                    acc_d           = '0;
                end else begin
                    acc_d = sum_s;
                end
            end
            DONE: begin
                out0_d      = res_q[0];
                out1_d      = res_q[1];
                out_valid_d = 1'b1;
                if (in_valid) begin
                    raw_d = in_s;
                end else begin
                    raw_d = raw_q;
                end
            end
            default: begin
                cnt_d = 3'd0;
                acc_d = '0;
            end
        endcase
    end

    // Datapath registers; reset abandons any job in flight and clears every output.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                raw_q[i] <= '0;
                act_q[i] <= '0;
            end
            res_q[0]    <= '0;
            res_q[1]    <= '0;
            cnt_q       <= 3'd0;
            acc_q       <= '0;
            out0_q      <= '0;
            out1_q      <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            raw_q       <= raw_d;
            act_q       <= act_d;
            res_q       <= res_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            out0_q      <= out0_d;
            out1_q      <= out1_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

endmodule
